// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - single-outstanding load/store unit for a word-organised data RAM (optional DMEM_LSU_MISALIGN_EN)
module dmem_lsu #(
   parameter int DM_AW = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic             res_exc,
   output logic [3:0]       dm_wen,
   output logic [DM_AW-1:0] dm_addr,
   output logic [31:0]      dm_wdata,
   input  logic [31:0]      dm_rdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

`ifdef DMEM_LSU_MISALIGN_EN
   // full address kept so a faulting access can report it
   localparam int AQ_W = 32;
`else
   localparam int AQ_W = 2;
`endif

   logic [1:0]       state_q;
   logic [3:0]       op_q;
   logic [AQ_W-1:0]  addr_q;
   logic [31:0]      res_data_q;
   logic [DM_AW-1:0] dm_addr_q;
   logic [31:0]      dm_wdata_q;
   logic             misalign;
   logic [3:0]       wen_lanes;
   logic [31:0]      st_lanes;
   logic [31:0]      ld_data;
   logic [31:0]      byte_shift;
   logic [15:0]      half_sel;

   assign req_ready = (state_q == S_IDLE);
   assign res_valid = (state_q == S_RESP);
   assign res_data  = res_data_q;
   assign dm_addr   = dm_addr_q;
   assign dm_wdata  = dm_wdata_q;

`ifdef DMEM_LSU_MISALIGN_EN
   logic res_exc_q;
   assign res_exc = res_exc_q;

   // half needs addr[0]=0, word needs addr[1:0]=0, size 11 always faults
   always_comb begin
      misalign = 1'b0;
      case (op_q[1:0])
         2'b01:   misalign = addr_q[0];
         2'b10:   misalign = (addr_q[1:0] != 2'b00);
         2'b11:   misalign = 1'b1;
         default: misalign = 1'b0;
      endcase
   end
`else
   logic unused_addr;
   assign unused_addr = ^req_addr[31:DM_AW+2];
   assign res_exc     = 1'b0;
   assign misalign    = 1'b0;
`endif

   // replicate store data across lanes at accept so dm_wdata is ready in ACCESS
   always_comb begin
      st_lanes = req_wdata;
      case (req_op[1:0])
         2'b00:   st_lanes = {4{req_wdata[7:0]}};
         2'b01:   st_lanes = {2{req_wdata[15:0]}};
         default: st_lanes = req_wdata;
      endcase
   end

   // byte enables from registered size/offset; size 11 behaves as word
   always_comb begin
      wen_lanes = 4'b1111;
      case (op_q[1:0])
         2'b00:   wen_lanes = 4'b0001 << addr_q[1:0];
         2'b01:   wen_lanes = addr_q[1] ? 4'b1100 : 4'b0011;
         default: wen_lanes = 4'b1111;
      endcase
   end

   // writes only in ACCESS; async reset leaves IDLE so dm_wen drops at once
   assign dm_wen = ((state_q == S_ACCESS) && op_q[3] && !misalign) ? wen_lanes : 4'b0000;

   // lane select and sign/zero extension of RAM read data
   always_comb begin
      byte_shift = dm_rdata >> {addr_q[1:0], 3'b000};
      half_sel   = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      ld_data    = dm_rdata;
      case (op_q[1:0])
         2'b00:   ld_data = {{24{byte_shift[7] & ~op_q[2]}}, byte_shift[7:0]};
         2'b01:   ld_data = {{16{half_sel[15] & ~op_q[2]}}, half_sel};
         default: ld_data = dm_rdata;
      endcase
   end

   // IDLE -> ACCESS -> RESP -> IDLE sequencing and result capture
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         op_q       <= 4'b0000;
         addr_q     <= '0;
         res_data_q <= 32'h0;
         dm_addr_q  <= '0;
         dm_wdata_q <= 32'h0;
`ifdef DMEM_LSU_MISALIGN_EN
         res_exc_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  op_q       <= req_op;
                  addr_q     <= req_addr[AQ_W-1:0];
                  dm_addr_q  <= req_addr[DM_AW+1:2];
                  dm_wdata_q <= st_lanes;
                  state_q    <= S_ACCESS;
               end
            end
            S_ACCESS: begin
`ifdef DMEM_LSU_MISALIGN_EN
               res_exc_q <= misalign;
               if (misalign)
                  res_data_q <= addr_q;
               else
`endif
               if (op_q[3])
                  res_data_q <= 32'h0;
               else
                  res_data_q <= ld_data;
               state_q <= S_RESP;
            end
            S_RESP: begin
               if (res_ready)
                  state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter DM_AW, default 5: word-address width of the attached data RAM (32 words).
REQ-002 SHALL have clk, input, 1: single clock; all state is updated on its rising edge.
REQ-003 SHALL have resetn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have req_valid, input, 1: memory request present.
REQ-005 SHALL have req_ready, output, 1: request accepted when req_valid and req_ready are both high at a clk edge.
REQ-006 SHALL have req_op, input, 4: [3]=store, [2]=unsigned load, [1:0]=size (00 byte, 01 half, 10 word, 11 reserved).
REQ-007 SHALL have req_addr, input, 32: byte address.
REQ-008 SHALL have req_wdata, input, 32: store data, right-aligned.
REQ-009 SHALL have res_valid, output, 1: result available.
REQ-010 SHALL have res_ready, input, 1: result consumed when res_valid and res_ready are both high at a clk edge.
REQ-011 SHALL have res_data, output, 32: load data, or the faulting address on an exception.
REQ-012 SHALL have res_exc, output, 1: address-error flag.
REQ-013 SHALL have dm_wen, output, 4: RAM byte write enables; bit 3 is byte [31:24].
REQ-014 SHALL have dm_addr, output, DM_AW: RAM word address.
REQ-015 SHALL have dm_wdata, output, 32: RAM write data.
REQ-016 SHALL have dm_rdata, input, 32: RAM read data, combinational from dm_addr.

Function
REQ-017 SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE, with req_ready high only in IDLE.
- IDLE: on accept, register op, addr and wdata, then go to ACCESS.
REQ-018 ACCESS SHALL last exactly one cycle.
- dm_addr = addr_q[DM_AW+1:2].
- Load: capture the aligned and extended dm_rdata into the result register.
- Store: assert dm_wen for this cycle only; the result data is 0.
- Then go to RESP.
REQ-019 RESP SHALL hold res_valid=1 with stable res_data/res_exc until res_ready=1, then go to IDLE.
- A new request is acceptable at the earliest one cycle after the RESP handshake.
REQ-020 Latency SHALL be: request accepted at edge N, RAM access in cycle N+1, res_valid high from edge N+2.
REQ-021 dm_wen SHALL be 4'b0000 in every state other than ACCESS, and also for loads.
REQ-022 Store lanes SHALL be:
- Byte: dm_wen = 1 << addr[1:0]; dm_wdata = {4{wdata[7:0]}}.
- Half: dm_wen = addr[1] ? 4'b1100 : 4'b0011; dm_wdata = {2{wdata[15:0]}}.
- Word: dm_wen = 4'b1111; dm_wdata = wdata.
REQ-023 Loads SHALL select the byte/half lane by addr[1:0]/addr[1].
- Sign-extend when req_op[2]=0; zero-extend when req_op[2]=1.
- req_op[2] SHALL be ignored for word loads.
REQ-024 Size 11 SHALL be treated as word.
REQ-025 Address bits above DM_AW+1 SHALL be ignored, so addresses wrap modulo the RAM size.
REQ-026 dm_addr and dm_wdata SHALL hold their last values outside ACCESS.

Reset
REQ-027 On resetn=0 the block SHALL asynchronously:
- set state to IDLE;
- drive req_ready=1 after release, res_valid=0, res_data=0, res_exc=0, dm_wen=0, dm_addr=0, dm_wdata=0.
REQ-028 Reset asserted mid-ACCESS SHALL force dm_wen to 0 before the next edge, so no RAM write occurs.
- Any pending result SHALL be discarded.

Configuration
REQ-029 With macro DMEM_LSU_MISALIGN_EN defined, the block SHALL detect misaligned accesses:
- Half with addr[0]=1, word with addr[1:0]!=0, or size 11.
- Such an access SHALL go through ACCESS with dm_wen=0, then RESP with res_exc=1 and res_data=req_addr.
REQ-030 With DMEM_LSU_MISALIGN_EN undefined:
- res_exc SHALL be constant 0.
- Half accesses SHALL ignore addr[0]; word accesses SHALL ignore addr[1:0].
- Size 11 SHALL be treated as word.

Verification
REQ-031 Store word: SW addr 0x0C data 0xDEADBEEF -> in ACCESS dm_addr=3, dm_wen=4'b1111; res_valid 2 cycles after accept, res_data=0.
REQ-032 Load byte, both extensions: with word 3=0xDEADBEEF, LB addr 0x0E -> 0xFFFFFFAD; LBU addr 0x0E -> 0x000000AD.
REQ-033 Store half, then load half: SH addr 0x12 data 0x00001234 -> dm_wen=4'b1100, dm_wdata=0x12341234; LHU addr 0x12 -> 0x00001234.
REQ-034 Result backpressure: res_ready held 0 for 5 cycles -> res_valid/res_data stable and req_ready=0 throughout; one accept follows the handshake.
REQ-035 Misaligned access (MISALIGN_EN defined): LW addr 0x05 -> dm_wen stays 0, res_exc=1, res_data=0x00000005; with the macro undefined -> word 1 is read and res_exc=0.
REQ-036 Reset mid-ACCESS: resetn pulled low during SW ACCESS before the edge -> dm_wen=0 immediately, RAM word unchanged, res_valid=0, state IDLE.
